// File: rtl/microwave_cook_ctrl.sv
// Cook sequencer: timer, run/pause/done control, magnetron duty cycling and end-of-cook beeper.
// The magnetron enable is gated combinationally by door_open so the drive drops in the cycle the door opens.
module microwave_cook_ctrl #(
    parameter int TIME_W     = 13,
    parameter int MAX_TIME   = 5999,
    parameter int ADD_SEC    = 30,
    parameter int BEEP_TICKS = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              btn_start,
    input  logic              btn_stop,
    input  logic              btn_add,
    input  logic              door_open,
    input  logic [1:0]        mode,
    output logic              idle,
    output logic              start,
    output logic              magnetron_en,
    output logic              light_on,
    output logic              beep,
    output logic [TIME_W-1:0] time_left,
    output logic [2:0]        state
);
    // state   | meaning
    // IDLE    | no time set, mode selection permitted
    // SET     | time entered, waiting for start
    // COOK    | timer running, magnetron duty cycled by phase vs mode_q
    // PAUSE   | door opened or stop pressed while cooking, timer held
    // DONE    | cook finished, beeper sounding for BEEP_TICKS ticks
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SET   = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int BEEP_W = $clog2(BEEP_TICKS + 1);
    localparam logic [TIME_W-1:0] ADD_T  = TIME_W'(ADD_SEC);
    localparam logic [TIME_W-1:0] MAX_T  = TIME_W'(MAX_TIME);
    localparam logic [TIME_W:0]   ADD_X  = (TIME_W+1)'(ADD_SEC);
    localparam logic [TIME_W:0]   MAX_X  = (TIME_W+1)'(MAX_TIME);
    localparam logic [BEEP_W-1:0] BEEP_T = BEEP_W'(BEEP_TICKS);

    state_t              state_q, state_d;
    logic [TIME_W-1:0]   time_q, time_d;
    logic [1:0]          phase_q, phase_d;
    logic [1:0]          mode_q, mode_d;
    logic [BEEP_W-1:0]   beep_cnt_q, beep_cnt_d;
    logic [TIME_W:0]     add_sum, cook_sum;
    logic [TIME_W-1:0]   add_sat, cook_sat;
    logic                dec;

    // Sums are one bit wider than the timer so the saturation compare never sees a wrapped value.
    always_comb begin
        dec      = tick && (time_q != '0);
        add_sum  = {1'b0, time_q} + ADD_X;
        add_sat  = (add_sum > MAX_X) ? MAX_T : add_sum[TIME_W-1:0];
        cook_sum = {1'b0, time_q} + (btn_add ? ADD_X : '0) - {{TIME_W{1'b0}}, dec};
        cook_sat = (cook_sum > MAX_X) ? MAX_T : cook_sum[TIME_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        time_d     = time_q;
        phase_d    = phase_q;
        mode_d     = mode_q;
        beep_cnt_d = beep_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (btn_start && !door_open) begin
                    state_d = ST_COOK;
                    time_d  = ADD_T;
                    mode_d  = mode;
                    phase_d = 2'd0;
                end else if (btn_add) begin
                    state_d = ST_SET;
                    time_d  = ADD_T;
                end
            end
            ST_SET: begin
                if (btn_stop) begin
                    state_d = ST_IDLE;
                    time_d  = '0;
                end else if (btn_start && !door_open) begin
                    state_d = ST_COOK;
                    mode_d  = mode;
                    phase_d = 2'd0;
                end else if (btn_add) begin
                    time_d = add_sat;
                end
            end
            ST_COOK: begin
                if (door_open || btn_stop) begin
                    state_d = ST_PAUSE;
                end else if (btn_add || tick) begin
                    time_d = cook_sat;
                    if (tick) phase_d = phase_q + 2'd1;
                    if (cook_sat == '0) begin
                        state_d    = ST_DONE;
                        beep_cnt_d = '0;
                    end
                end
            end
            ST_PAUSE: begin
                if (btn_stop) begin
                    state_d = ST_IDLE;
                    time_d  = '0;
                end else if (btn_start && !door_open) begin
                    state_d = ST_COOK;
                    mode_d  = mode;
                end else if (btn_add) begin
                    time_d = add_sat;
                end
            end
            ST_DONE: begin
                if (door_open || btn_start || btn_stop || btn_add) begin
                    state_d    = ST_IDLE;
                    beep_cnt_d = '0;
                end else if (tick) begin
                    beep_cnt_d = beep_cnt_q + 1'b1;
                    if (beep_cnt_d == BEEP_T) begin
                        state_d    = ST_IDLE;
                        beep_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                time_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            time_q     <= '0;
            phase_q    <= 2'd0;
            mode_q     <= 2'd0;
            beep_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            phase_q    <= phase_d;
            mode_q     <= mode_d;
            beep_cnt_q <= beep_cnt_d;
        end
    end

    assign state        = state_q;
    assign time_left    = time_q;
    assign idle         = (state_q == ST_IDLE) || (state_q == ST_SET);
    assign start        = (state_q == ST_COOK);
    assign magnetron_en = (state_q == ST_COOK) && !door_open && (phase_q <= mode_q);
    assign light_on     = door_open || (state_q == ST_COOK);
    assign beep         = (state_q == ST_DONE);
endmodule

// File: doc/microwave_cook_ctrl.md
Name: microwave_cook_ctrl

Overview:
- Top-level cook sequencer for the microwave. Owns the cook timer, run/pause/done state, magnetron power duty cycling and the end-of-cook beeper.
- Drives the `idle`/`start` qualifiers consumed by btn_modeSelect and consumes its 2-bit `mode` power level.
- Sits between the debounced front-panel buttons/door switch and the display/magnetron drivers.

Parameters:
- TIME_W, 13, width of the seconds counter.
- MAX_TIME, 5999, saturation limit in seconds (99:59).
- ADD_SEC, 30, seconds added per btn_add press or quick-start.
- BEEP_TICKS, 3, number of 1 Hz ticks the beeper sounds in DONE.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle 1 Hz enable pulse.
- btn_start  input  1  single-cycle debounced start press.
- btn_stop  input  1  single-cycle debounced stop/clear press.
- btn_add  input  1  single-cycle debounced +ADD_SEC press.
- door_open  input  1  level, 1 = door open.
- mode  input  2  power level from btn_modeSelect (0 = 25% … 3 = 100%).
- idle  output  1  1 in IDLE/SET; mode selection permitted.
- start  output  1  1 in COOK; mode selection locked.
- magnetron_en  output  1  magnetron drive.
- light_on  output  1  cavity lamp.
- beep  output  1  beeper drive.
- time_left  output  TIME_W  remaining seconds.
- state  output  3  IDLE=0, SET=1, COOK=2, PAUSE=3, DONE=4.

Behaviour:

Reset (synchronous, rst=1 at posedge):
- state=IDLE, time_left=0, phase=0, mode_q=0, beep_cnt=0.
- Outputs: idle=1, start=0, magnetron_en=0, light_on=door_open, beep=0.
- Reset in any state, including mid-COOK, aborts immediately.

General:
- All state, time_left and counter updates are registered.
- Latency: one clock from qualifying input to new state/time.
- Add rule: time_left = min(time_left + ADD_SEC, MAX_TIME), saturating and computed TIME_W+1 wide.
- Input priority within a cycle: door_open > btn_stop > btn_start > btn_add/tick.

IDLE:
- btn_add → time_left=ADD_SEC, go to SET.
- btn_start with door closed → quick start: time_left=ADD_SEC, latch mode_q=mode, phase=0, go to COOK.
- btn_start with door open → ignored.

SET:
- btn_add → add (saturating).
- btn_stop → time_left=0, go to IDLE.
- btn_start with door closed → latch mode_q, phase=0, go to COOK.

COOK:
- door_open or btn_stop → PAUSE; time_left held.
- tick → time_left−1 and phase+1 (2-bit, wraps).
- tick with time_left==1 → time_left=0, beep_cnt=0, go to DONE.
- btn_add and tick in the same cycle → net time_left+ADD_SEC−1, with saturation applied after the decrement.

PAUSE:
- tick ignored; time_left and phase held.
- btn_start with door closed → COOK, mode_q re-latched, phase preserved.
- btn_stop → time_left=0, go to IDLE.
- btn_add → add.

DONE:
- beep=1.
- Each tick increments beep_cnt; when beep_cnt reaches BEEP_TICKS → IDLE, beep=0.
- Any button press or door_open → IDLE immediately.

Outputs:
- magnetron_en = (state==COOK) & ~door_open & (phase <= mode_q). Combinational on door_open as a safety interlock: it falls in the same cycle the door opens.
- Duty cycle over each 4-tick window is (mode_q+1)/4.
- light_on = door_open | (state==COOK).
- start = (state==COOK); idle = (state==IDLE | state==SET).
- mode changes during COOK have no effect until the next entry to COOK.

Test Plan:
1. Reset, then btn_add ×3, then btn_start with door closed → state SET with time_left=90, then COOK; mode=3 gives magnetron_en=1 continuously; after 90 ticks state=DONE and time_left=0.
2. mode=1, SET 30 s, start → magnetron_en high for ticks 0–1 and low for ticks 2–3 of each 4-tick window; mode driven to 3 mid-cook leaves the pattern unchanged.
3. COOK at time_left=50, door_open=1 → magnetron_en=0 in the same cycle, state=PAUSE next cycle, time_left stays 50 across ticks. Door closed + btn_start → COOK resumes from 50.
4. btn_add ×200 in SET → time_left saturates at 5999. Then btn_add coincident with tick in COOK at 100 → time_left=129.
5. DONE → beep=1 for 3 ticks, then IDLE. In a second run, btn_stop in DONE → IDLE next cycle with beep=0.
6. btn_start in IDLE with door open → no change. Door closed + btn_start → COOK with time_left=30. rst asserted mid-COOK → IDLE, time_left=0, magnetron_en=0 next cycle.
